// File: rtl/fpu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide responder.
// Holds the FPUOp encodings, the controller state enum and the constant
// returned for a divide by zero.
package fpu_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;  // signed multiply
  localparam logic [2:0] OP_MULTU = 3'b001;  // unsigned multiply
  localparam logic [2:0] OP_DIV   = 3'b010;  // signed divide
  localparam logic [2:0] OP_DIVU  = 3'b011;  // unsigned divide

  localparam logic [31:0] DIV_ZERO_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } fpu_state_e;

endpackage

// File: rtl/fpu_muldiv_seq_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
// Ports:
//   is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   acc      - 2*WIDTH accumulator {hi, lo}
//   operand  - multiplicand (multiply) or divisor (divide), both magnitudes
//   acc_next - accumulator after this iteration
// Multiply: lo holds the unconsumed multiplier bits, hi the partial sum.
//   Add the multiplicand into hi when lo[0] is set, then shift the whole
//   accumulator right, pulling the adder carry into the top.
// Divide: hi holds the partial remainder, lo the dividend bits still to be
//   consumed (MSB first) and, from the bottom, the quotient bits produced.
module muldiv_step
  import fpu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    hi      = acc[2*WIDTH-1:WIDTH];
    lo      = acc[WIDTH-1:0];
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted = {hi, lo[WIDTH-1]};
    // The remainder is always below the divisor, so shifted fits in WIDTH+1
    // bits and the top bit of trial is a clean borrow indicator.
    trial   = shifted - {1'b0, operand};
    if (is_div) begin
      if (trial[WIDTH]) begin
        acc_next = {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {add_sum, lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/fpu_muldiv_seq.sv
// Iterative 32-bit multiply/divide responder.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   req_valid/ready  - request handshake; FPUOp, A, B qualify the request
//   resp_valid/ready - response handshake; F, div_zero, ill_op qualify it
//   dbg_state        - current controller state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE. resp_valid, once high, stays
// high with F and flags frozen until a cycle where resp_ready is high.
// Operands are converted to magnitudes on accept; 32 unsigned iterations
// run in CALC and the sign is applied in FIX. resp_valid is registered off
// the DONE state, so it rises one edge after DONE is entered.
module fpu_muldiv_seq
  import fpu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       FPUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] F,
  output logic             div_zero,
  output logic             ill_op,
  output fpu_state_e       dbg_state
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  fpu_state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               sign_q;

  // Request decode, only meaningful in IDLE.
  logic             op_illegal;
  logic             op_is_div;
  logic             op_signed;
  logic             b_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             resp_fire;

  always_comb begin
    op_illegal = FPUOp[2];
    op_is_div  = FPUOp[1];
    op_signed  = ~FPUOp[0];
    b_zero     = (B == '0);
    mag_a      = (op_signed && A[WIDTH-1]) ? -A : A;
    mag_b      = (op_signed && B[WIDTH-1]) ? -B : B;
  end

  assign resp_fire = resp_valid & resp_ready;
  assign req_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (op_illegal)             state_d = ST_DONE;
          else if (op_is_div && b_zero) state_d = ST_DONE;
          else                        state_d = ST_CALC;
        end
      end
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (resp_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      sign_q     <= 1'b0;
      F          <= '0;
      div_zero   <= 1'b0;
      ill_op     <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            is_div_q <= op_is_div;
            sign_q   <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            // Dividend / multiplier sits in the low half; the other operand
            // is held steady for all iterations.
            acc_q    <= {{WIDTH{1'b0}}, mag_a};
            opnd_q   <= mag_b;
            cnt_q    <= '0;
            ill_op   <= op_illegal;
            div_zero <= ~op_illegal & op_is_div & b_zero;
            if (op_illegal)               F <= '0;
            else if (op_is_div && b_zero) F <= WIDTH'(DIV_ZERO_RESULT);
          end
        end
        ST_CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          // Low half is the product's low bits or the quotient; negating the
          // magnitude gives the correctly wrapped signed result.
          F <= sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
        ST_DONE: begin
          if (resp_fire) begin
            resp_valid <= 1'b0;
            div_zero   <= 1'b0;
            ill_op     <= 1'b0;
          end else begin
            resp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
